// File: rtl/pip16_cla_sub.sv
// ----------------------------------------------------------------------------
// pip16_cla_sub : pipelined 16-bit carry-lookahead subtractor, diff = a - b - bin
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pip16_cla_sub #(
  parameter int REG_IN = 1,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("pip16_cla_sub: only WIDTH=16 is supported");
    end
  endgenerate

  // Returns carries {c4,c3,c2,c1} of one 4-bit lookahead block.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic        s1_v;
  logic [15:0] s1_a;
  logic [15:0] s1_nb;
  logic        s1_cin;

  generate
    if (REG_IN != 0) begin : g_reg_in
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v   <= 1'b0;
          s1_a   <= '0;
          s1_nb  <= '0;
          s1_cin <= 1'b0;
        end else if (en) begin
          s1_v   <= in_valid;
          s1_a   <= a;
          s1_nb  <= ~b;
          s1_cin <= ~bin;
        end
      end
    end else begin : g_no_reg_in
      assign s1_v   = in_valid;
      assign s1_a   = a;
      assign s1_nb  = ~b;
      assign s1_cin = ~bin;
    end
  endgenerate

  logic        s2_v, s3_v, s4_v, s5_v;
  logic [15:0] s2_p, s3_p, s4_p, s5_p;
  logic [15:0] s2_g;
  logic [15:4] s3_g;
  logic [15:8] s4_g;
  logic [15:12] s5_g;
  logic        s2_cin;
  logic [4:0]  s3_c;
  logic [8:0]  s4_c;
  logic [12:0] s5_c;

  logic [3:0]  w3_c, w4_c, w5_c, w6_c;
  logic [16:0] w_c_all;
  logic [15:0] w_diff;

  // Each lookahead block consumes the carry registered by the previous stage.
  assign w3_c    = cla4(s2_p[3:0],   s2_g[3:0],   s2_cin);
  assign w4_c    = cla4(s3_p[7:4],   s3_g[7:4],   s3_c[4]);
  assign w5_c    = cla4(s4_p[11:8],  s4_g[11:8],  s4_c[8]);
  assign w6_c    = cla4(s5_p[15:12], s5_g[15:12], s5_c[12]);
  assign w_c_all = {w6_c, s5_c};
  assign w_diff  = s5_p ^ w_c_all[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      s2_p      <= '0;
      s2_g      <= '0;
      s2_cin    <= 1'b0;
      s3_v      <= 1'b0;
      s3_p      <= '0;
      s3_g      <= '0;
      s3_c      <= '0;
      s4_v      <= 1'b0;
      s4_p      <= '0;
      s4_g      <= '0;
      s4_c      <= '0;
      s5_v      <= 1'b0;
      s5_p      <= '0;
      s5_g      <= '0;
      s5_c      <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      s2_v      <= s1_v;
      s2_p      <= s1_a ^ s1_nb;
      s2_g      <= s1_a & s1_nb;
      s2_cin    <= s1_cin;

      s3_v      <= s2_v;
      s3_p      <= s2_p;
      s3_g      <= s2_g[15:4];
      s3_c      <= {w3_c, s2_cin};

      s4_v      <= s3_v;
      s4_p      <= s3_p;
      s4_g      <= s3_g[15:8];
      s4_c      <= {w4_c, s3_c};

      s5_v      <= s4_v;
      s5_p      <= s4_p;
      s5_g      <= s4_g[15:12];
      s5_c      <= {w5_c, s4_c};

      out_valid <= s5_v;
      diff      <= w_diff;
      bout      <= ~w_c_all[16];
      zero      <= (w_diff == 16'h0000);
      neg       <= w_diff[15];
      ovf       <= w_c_all[15] ^ w_c_all[16];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pip16_cla_sub.sv
// ----------------------------------------------------------------------------
// tb_pip16_cla_sub : directed + random bench for pip16_cla_sub against an arithmetic model
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pip16_cla_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
  } op_t;

  // Slot k holds the operation captured k enabled edges ago; slot 5 is on the outputs.
  op_t pipe [6];

  pip16_cla_sub #(.REG_IN(1), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // {bout, zero, neg, ovf, diff} from plain integer arithmetic
  function automatic logic [19:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int ux, uy, sx, sy, bii, ud, sd;
    logic [15:0] d;
    ux  = x;
    uy  = y;
    sx  = $signed(x);
    sy  = $signed(y);
    bii = bi;
    ud  = ux - uy - bii;
    sd  = sx - sy - bii;
    d   = 16'(ud);
    return {ud < 0, d == 16'h0000, d[15], (sd > 32767) || (sd < -32768), d};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 6; i++) pipe[i] = '0;
  endtask

  task automatic check_outputs();
    logic [19:0] r;
    chk("out_valid", {15'b0, out_valid}, {15'b0, pipe[5].v});
    if (pipe[5].v) begin
      r = ref_sub(pipe[5].a, pipe[5].b, pipe[5].bin);
      chk("diff", diff,             r[15:0]);
      chk("bout", {15'b0, bout},    {15'b0, r[19]});
      chk("zero", {15'b0, zero},    {15'b0, r[18]});
      chk("neg",  {15'b0, neg},     {15'b0, r[17]});
      chk("ovf",  {15'b0, ovf},     {15'b0, r[16]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " out_valid"}, {15'b0, out_valid}, 16'h0000);
    chk({tag, " diff"},      diff,               16'h0000);
    chk({tag, " bout"},      {15'b0, bout},      16'h0000);
    chk({tag, " zero"},      {15'b0, zero},      16'h0000);
    chk({tag, " neg"},       {15'b0, neg},       16'h0000);
    chk({tag, " ovf"},       {15'b0, ovf},       16'h0000);
  endtask

  task automatic step(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                      input logic bni, input logic e);
    in_valid = v;
    a        = ai;
    b        = bi;
    bin      = bni;
    en       = e;
    @(posedge clk);
    if (rst_n && e) begin
      for (int i = 5; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {v, ai, bi, bni};
    end
    #1;
    check_outputs();
  endtask

  task automatic bubble();
    step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic rand_op(input logic e);
    step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), e);
  endtask

  task automatic run_one(input string tag, input logic [15:0] ai, input logic [15:0] bi, input logic bni,
                         input logic [15:0] ed, input logic eb, input logic ez, input logic en_, input logic eo);
    step(1'b1, ai, bi, bni, 1'b1);
    repeat (5) bubble();
    chk({tag, " out_valid"}, {15'b0, out_valid}, 16'h0001);
    chk({tag, " diff"},      diff,               ed);
    chk({tag, " bout"},      {15'b0, bout},      {15'b0, eb});
    chk({tag, " zero"},      {15'b0, zero},      {15'b0, ez});
    chk({tag, " neg"},       {15'b0, neg},       {15'b0, en_});
    chk({tag, " ovf"},       {15'b0, ovf},       {15'b0, eo});
    bubble();
    chk({tag, " single pulse"}, {15'b0, out_valid}, 16'h0000);
  endtask

  initial begin
    clear_model();
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    #1;
    check_all_zero("reset");
    rand_op(1'b1);
    rand_op(1'b1);
    check_all_zero("reset held");
    rst_n = 1'b1;

    // Directed corner vectors
    run_one("basic",      16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("borrow b",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("borrow bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("overflow",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("zero",       16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("pos ovf",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Streaming: 8 back-to-back, one bubble, then drain
    repeat (8) rand_op(1'b1);
    bubble();
    repeat (6) bubble();

    // Stall with 4 in flight, the oldest already on the outputs
    repeat (4) rand_op(1'b1);
    repeat (2) bubble();
    repeat (3) rand_op(1'b0);
    repeat (6) bubble();

    // Random traffic with random enable toggling
    repeat (80) step(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
                     1'($urandom), 1'($urandom_range(2) != 0));
    repeat (6) bubble();

    // Reset mid-stream, asserted between edges while stalled
    repeat (6) rand_op(1'b1);
    rand_op(1'b0);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_all_zero("async reset");
    rand_op(1'b1);
    #3;
    rst_n = 1'b1;
    repeat (8) bubble();
    rand_op(1'b1);
    repeat (6) bubble();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
